// File: rtl/pool_row_pairer.sv
// Pairs each odd-row pixel with the buffered even-row pixel above it for 2x2 pooling.
// Outputs registered one cycle after the odd-row beat; valid-only, no backpressure.
module pool_row_pairer #(
  parameter int DATA_WIDTH = 16,
  parameter int ROW_WIDTH  = 24,
  parameter int NUM_ROWS   = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic [DATA_WIDTH-1:0]      data_in,
  output logic                       valid_out,
  output logic [1:0][DATA_WIDTH-1:0] column_out,
  output logic                       row_last,
  output logic                       frame_last
);

  localparam int PAIRS = NUM_ROWS / 2;
  localparam int XW    = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
  localparam int PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(ROW_WIDTH - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PAIRS - 1);

  typedef enum logic {FILL, PAIR} state_t;

  state_t                       state_q, state_d;
  logic [XW-1:0]                x_q, x_d;
  logic [PW-1:0]                pair_q, pair_d;
  logic                         valid_q, valid_d;
  logic                         row_last_q, row_last_d;
  logic                         frame_last_q, frame_last_d;
  logic [1:0][DATA_WIDTH-1:0]   column_q, column_d;
  logic                         buf_we;
  logic [DATA_WIDTH-1:0]        row_buf_q [ROW_WIDTH];

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    pair_d       = pair_q;
    valid_d      = 1'b0;
    row_last_d   = 1'b0;
    frame_last_d = 1'b0;
    column_d     = column_q;
    buf_we       = 1'b0;
    if (valid_in) begin
      x_d = (x_q == X_LAST) ? '0 : x_q + 1'b1;
      case (state_q)
        FILL: begin
          buf_we = 1'b1;
          if (x_q == X_LAST) state_d = PAIR;
        end
        PAIR: begin
          valid_d     = 1'b1;
          column_d[0] = row_buf_q[x_q];
          column_d[1] = data_in;
          if (x_q == X_LAST) begin
            row_last_d = 1'b1;
            state_d    = FILL;
            if (pair_q == P_LAST) begin
              frame_last_d = 1'b1;
              pair_d       = '0;
            end else begin
              pair_d = pair_q + 1'b1;
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FILL;
      x_q          <= '0;
      pair_q       <= '0;
      valid_q      <= 1'b0;
      row_last_q   <= 1'b0;
      frame_last_q <= 1'b0;
      column_q     <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      pair_q       <= pair_d;
      valid_q      <= valid_d;
      row_last_q   <= row_last_d;
      frame_last_q <= frame_last_d;
      column_q     <= column_d;
    end
  end

  // Row buffer holds data only; a stale entry is always rewritten by FILL before PAIR reads it.
  always_ff @(posedge clk) begin
    if (buf_we) row_buf_q[x_q] <= data_in;
  end

  assign valid_out  = valid_q;
  assign column_out = column_q;
  assign row_last   = row_last_q;
  assign frame_last = frame_last_q;

endmodule

// File: tb/tb_pool_row_pairer.sv
// Directed bench for pool_row_pairer: 24x24 instance plus a 2x2 minimum-size instance.
module tb_pool_row_pairer;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             valid_in = 1'b0;
  logic [15:0]      data_in = '0;
  logic             valid_out, row_last, frame_last;
  logic [1:0][15:0] column_out;

  logic             s_valid_in = 1'b0;
  logic [15:0]      s_data_in = '0;
  logic             s_valid_out, s_row_last, s_frame_last;
  logic [1:0][15:0] s_column_out;

  int nvec = 0;
  int nerr = 0;

  int          cyc = 0;
  bit          vin_at_edge = 1'b0;
  int          gap_viol = 0;
  int          flag_viol = 0;
  logic [15:0] q_up[$];
  logic [15:0] q_lo[$];
  bit          q_rl[$];
  bit          q_fl[$];
  int          q_cyc[$];
  int          b_cyc[$];

  always #5 clk = ~clk;

  pool_row_pairer #(.DATA_WIDTH(16), .ROW_WIDTH(24), .NUM_ROWS(24)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .valid_out(valid_out), .column_out(column_out), .row_last(row_last), .frame_last(frame_last)
  );

  pool_row_pairer #(.DATA_WIDTH(16), .ROW_WIDTH(2), .NUM_ROWS(2)) dut_small (
    .clk(clk), .rst(rst), .valid_in(s_valid_in), .data_in(s_data_in),
    .valid_out(s_valid_out), .column_out(s_column_out), .row_last(s_row_last),
    .frame_last(s_frame_last)
  );

  // Beat accepted at edge N shows its column after edge N, so both are tagged with cycle N.
  always @(posedge clk) begin
    cyc++;
    vin_at_edge = valid_in && rst;
    if (valid_in && rst) b_cyc.push_back(cyc);
  end

  always @(negedge clk) begin
    if (valid_out && !vin_at_edge) gap_viol++;
    if ((row_last && !valid_out) || (frame_last && !row_last)) flag_viol++;
    if (valid_out) begin
      q_up.push_back(column_out[0]);
      q_lo.push_back(column_out[1]);
      q_rl.push_back(row_last);
      q_fl.push_back(frame_last);
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    q_up.delete(); q_lo.delete(); q_rl.delete(); q_fl.delete();
    q_cyc.delete(); b_cyc.delete();
  endtask

  task automatic drive(input logic [15:0] d, input int gap);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  task automatic send_rows(input int nrows, input int maxgap, input bit chk_row0);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < 24; c++) begin
        drive(16'(100 * r + c), (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
        if (chk_row0 && r == 1 && c == 0) chk("no_out_row0", q_up.size(), 0);
      end
    end
  endtask

  // Pulse k of a frame: pair r = k/24, column c = k%24; upper row 2r, lower row 2r+1.
  task automatic chk_pulses(input string tag, input int first, input int n, input bit lat);
    for (int k = 0; k < n; k++) begin
      int idx, kk, f, r, c;
      idx = first + k;
      f   = k / 288;
      kk  = k % 288;
      r   = kk / 24;
      c   = kk % 24;
      chk({tag, "_up"}, q_up[idx], 200 * r + c);
      chk({tag, "_lo"}, q_lo[idx], 200 * r + 100 + c);
      chk({tag, "_rl"}, q_rl[idx], (c == 23) ? 1 : 0);
      chk({tag, "_fl"}, q_fl[idx], (r == 11 && c == 23) ? 1 : 0);
      if (lat) chk({tag, "_lat"}, q_cyc[idx], b_cyc[f * 576 + (2 * r + 1) * 24 + c]);
    end
  endtask

  initial begin
    int nrl;

    #1;
    chk("rst_vld", valid_out, 0);
    chk("rst_col", column_out, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      valid_in = ~valid_in;
      data_in  = 16'($urandom);
      chk("rst_hold_vld", {valid_out, row_last, frame_last}, 0);
      chk("rst_hold_col", column_out, 0);
    end
    @(negedge clk);
    valid_in = 1'b0;
    rst      = 1'b1;
    clear_logs();
    gap_viol  = 0;
    flag_viol = 0;

    send_rows(24, 0, 1'b1);
    send_rows(24, 0, 1'b0);
    idle(3);
    chk("two_frames_pulses", q_up.size(), 576);
    nrl = 0;
    foreach (q_rl[i]) if (q_rl[i]) nrl++;
    chk("two_frames_row_last", nrl, 24);
    if (q_up.size() == 576) chk_pulses("frame", 0, 576, 1'b1);
    chk("frame_gap_viol", gap_viol, 0);
    chk("frame_flag_viol", flag_viol, 0);

    clear_logs();
    send_rows(4, 5, 1'b0);
    idle(3);
    chk("gapped_pulses", q_up.size(), 48);
    if (q_up.size() == 48) chk_pulses("gapped", 0, 48, 1'b0);
    chk("gapped_gap_viol", gap_viol, 0);
    chk("gapped_flag_viol", flag_viol, 0);

    // Mid-frame reset between clock edges at row 1, column 10 of a fresh frame.
    idle(1);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    send_rows(1, 0, 1'b0);
    for (int c = 0; c < 10; c++) drive(16'(100 + c), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("async_rst_vld", valid_out, 0);
    chk("async_rst_col", column_out, 0);
    idle(3);
    clear_logs();
    rst = 1'b1;
    send_rows(2, 0, 1'b0);
    idle(3);
    chk("restart_pulses", q_up.size(), 24);
    if (q_up.size() == 24) chk_pulses("restart", 0, 24, 1'b1);

    @(negedge clk);
    s_valid_in = 1'b1; s_data_in = 16'd5;
    @(negedge clk);
    s_data_in = 16'd7;
    chk("small_fill_vld", s_valid_out, 0);
    @(negedge clk);
    s_data_in = 16'd9;
    chk("small_fill_vld2", s_valid_out, 0);
    @(negedge clk);
    s_data_in = 16'd3;
    chk("small_p0_vld", s_valid_out, 1);
    chk("small_p0_up", s_column_out[0], 5);
    chk("small_p0_lo", s_column_out[1], 9);
    chk("small_p0_last", {s_row_last, s_frame_last}, 0);
    @(negedge clk);
    s_valid_in = 1'b0;
    chk("small_p1_vld", s_valid_out, 1);
    chk("small_p1_up", s_column_out[0], 7);
    chk("small_p1_lo", s_column_out[1], 3);
    chk("small_p1_last", {s_row_last, s_frame_last}, 2'b11);
    @(negedge clk);
    chk("small_idle_vld", {s_valid_out, s_row_last, s_frame_last}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pool_row_pairer.md
# pool_row_pairer

Line-buffer stage directly upstream of the 2x2 max-pooling layer. Accepts the convolution feature map as a raster stream (one pixel per valid beat, row-major) and emits, for every pixel of each odd row, a two-element column holding the vertically adjacent pixels from the even row above and the current odd row. This is the `[1:0][15:0]` column format and valid-only handshake the pooling layer consumes.

## Interface
- `DATA_WIDTH`, 16: pixel width in bits.
- `ROW_WIDTH`, 24: pixels per feature-map row. Must be even and ≥ 2.
- `NUM_ROWS`, 24: rows per feature map. Must be even and ≥ 2.

- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-low reset (0 = reset asserted).
- `valid_in`  in  1: `data_in` carries a pixel this cycle.
- `data_in`  in  DATA_WIDTH: pixel value, raster order.
- `valid_out`  out  1: `column_out` is valid this cycle (single-cycle pulse per column).
- `column_out`  out  2 x DATA_WIDTH: [0] = pixel from the even (upper) row, [1] = pixel from the odd (lower) row, same x.
- `row_last`  out  1: high with `valid_out` on the last column (x = ROW_WIDTH-1) of a row pair.
- `frame_last`  out  1: high with `valid_out` on the final column of the final row pair.

## Operation
- Storage: ROW_WIDTH x DATA_WIDTH row buffer, indexed by column counter `x`. The row buffer is not reset.
- Counters:
  - `x` runs 0..ROW_WIDTH-1.
  - `pair` runs 0..NUM_ROWS/2-1.
  - Both advance only on accepted beats (`valid_in`=1).
- FSM states:
  - FILL (even row): each beat writes `data_in` to `buf[x]`. No output. When x = ROW_WIDTH-1, x wraps to 0 and the FSM moves to PAIR.
  - PAIR (odd row): each beat registers `column_out` = {`buf[x]`, `data_in`} and pulses `valid_out`. When x = ROW_WIDTH-1, x wraps to 0, `row_last` is asserted, `pair` increments, and the FSM returns to FILL.
  - End of frame: when `pair` = NUM_ROWS/2-1 at the end of the row, `frame_last` is asserted and `pair` wraps to 0. The next beat starts a new frame in FILL.
- Input gaps: `valid_in` may drop for any number of cycles. Counters, state and buffer hold, and outputs deassert.
- No backpressure: the downstream stage always accepts.
- Data path: values pass through bit-exact, with no arithmetic. Signed interpretation belongs downstream.
- Buffer writes: none occur in PAIR. The row buffer is overwritten only by the next FILL row.

## Timing
- Reset (`rst`=0, asynchronous): state = FILL, x = 0, pair = 0. `valid_out`, `row_last` and `frame_last` = 0. `column_out` = 0. Reset takes effect immediately and holds while `rst` is low.
- Reset mid-row or mid-frame: the partial row is discarded. The first beat after release is treated as pixel (0,0) of a new frame.
- Reset release: the first beat may arrive on the first rising edge with `rst`=1.
- Latency: `valid_out`, `column_out`, `row_last` and `frame_last` are registered, one cycle after the accepted odd-row beat.
- Throughput: one pixel per cycle sustained. Output rate is ROW_WIDTH columns per 2·ROW_WIDTH input beats.
- Output pulses:
  - `valid_out` is high exactly one cycle per odd-row beat.
  - `row_last` and `frame_last` are never high without `valid_out`.
  - `frame_last` implies `row_last`.
- Boundary case: the FILL→PAIR transition has no bubble. A beat arriving the cycle after the last even-row beat is paired with `buf[0]`.

## Test plan
- Reset values: hold `rst`=0, toggle `valid_in` with random data → all outputs stay 0. Release, then stream row 0 = 0..23 → no `valid_out` during row 0.
- Pairing with ROW_WIDTH=24 and pixel value = 100·row + col: stream rows 0 and 1 continuously → 24 pulses. Pulse k gives `column_out` = {k, 100+k}, registered one cycle after beat 24+k. `row_last` is set on the 24th pulse only.
- Full frame with 24x24 continuous input → 288 `valid_out` pulses and 12 `row_last` pulses. `frame_last` fires only on the pulse carrying {2200+23, 2300+23}. A second frame immediately after repeats the same output.
- Gapped input: insert random 0–5 cycle gaps in `valid_in` across rows 0–3 → output values and order are identical to the gap-free run, and no `valid_out` appears during gaps.
- Mid-operation reset: assert `rst` low asynchronously (between clock edges) at row 1, column 10, then restart the stream from (0,0) → no output until the new row 1. The first column is {0, 100}. No stale columns appear.
- Minimum size: ROW_WIDTH=2, NUM_ROWS=2, input 5, 7, 9, 3 → output {5,9} then {7,3}. `row_last` and `frame_last` are both high on the second pulse.
